// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its helpers.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 12;
   localparam int DMEM_DATA_W = 32;

   // Arbiter state: idle, host waiting behind the CPU, or CPU held off for the host
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } arb_state_e;

   // One memory access as presented to the single dmem port
   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/starve_counter.sv
// 8-bit saturating counter of host-blocked cycles. hit_o looks at the value the
// counter is about to take, so the arbiter can register cpu_hold in the same
// cycle the threshold is reached.
module starve_counter #(
   parameter int unsigned MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic hit_o
);

   localparam logic [7:0] MAX_C = 8'(MAX);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: clear wins over increment, increment stops at 0xFF
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 8'd0;
      end else if (inc_i && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
      hit_o = (count_d >= MAX_C);
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MM stage and a host port.
// The CPU always wins; a starvation FSM raises cpu_hold so the host eventually
// gets a slot.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W     = DMEM_ADDR_W,
   parameter int unsigned DATA_W     = DMEM_DATA_W,
   parameter int unsigned STARVE_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hold,
   input  logic              host_req_valid,
   output logic              host_req_ready,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_rsp_valid,
   output logic [DATA_W-1:0] host_rsp_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err_collision
);

   arb_state_e        state_q;
   logic              cpu_hold_q;
   logic              err_collision_q;
   logic              rsp_pend_q;
   logic              rsp_is_rd_q;
   logic [ADDR_W-1:0] addr_q;

   logic      accept;
   logic      cnt_inc;
   logic      cnt_clr;
   logic      cnt_hit;
   dmem_req_t cpu_r;
   dmem_req_t host_r;
   dmem_req_t grant_r;

   // Grant: CPU first, then an accepted host request, otherwise keep the address
   always_comb begin
      host_req_ready = !cpu_req;
      accept         = host_req_valid && host_req_ready;
      cpu_r          = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
      host_r         = '{we: host_we, addr: host_addr, wdata: host_wdata};
      grant_r        = '{we: 1'b0, addr: addr_q, wdata: '0};
      if (cpu_req) begin
         grant_r = cpu_r;
      end else if (accept) begin
         grant_r = host_r;
      end
      mem_addr  = grant_r.addr;
      mem_we    = grant_r.we;
      mem_wdata = grant_r.wdata;
   end

   // Starvation counting: every blocked cycle outside HOLD counts; any accept
   // or an abandoned request resets the count
   always_comb begin
      cnt_inc = host_req_valid && !accept && (state_q != HOLD);
      cnt_clr = accept || !host_req_valid;
   end

   starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (cnt_inc),
      .clr_i (cnt_clr),
      .hit_o (cnt_hit)
   );

   // Starvation FSM with registered cpu_hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cpu_hold_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, WAIT: begin
               if (!host_req_valid || accept) begin
                  state_q    <= IDLE;
                  cpu_hold_q <= 1'b0;
               end else if (cnt_hit) begin
                  state_q    <= HOLD;
                  cpu_hold_q <= 1'b1;
               end else begin
                  state_q    <= WAIT;
                  cpu_hold_q <= 1'b0;
               end
            end
            HOLD: begin
               // A colliding CPU keeps the slot; the host keeps waiting in HOLD
               if (!host_req_valid || accept) begin
                  state_q    <= IDLE;
                  cpu_hold_q <= 1'b0;
               end else begin
                  state_q    <= HOLD;
                  cpu_hold_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               cpu_hold_q <= 1'b0;
            end
         endcase
      end
   end

   // Host response tracking, held address and sticky collision flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_pend_q      <= 1'b0;
         rsp_is_rd_q     <= 1'b0;
         addr_q          <= '0;
         err_collision_q <= 1'b0;
      end else begin
         rsp_pend_q  <= accept;
         rsp_is_rd_q <= accept && !host_we;
         if (cpu_req || accept) begin
            addr_q <= grant_r.addr;
         end
         if (cpu_req && cpu_hold_q) begin
            err_collision_q <= 1'b1;
         end
      end
   end

   // Outputs: read data is only forwarded for host reads
   always_comb begin
      cpu_rdata      = mem_rdata;
      cpu_hold       = cpu_hold_q;
      err_collision  = err_collision_q;
      host_rsp_valid = rsp_pend_q;
      host_rsp_data  = (rsp_pend_q && rsp_is_rd_q) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (STARVE_MAX = 3) with a behavioural dmem.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_hold;
   logic        host_req_valid = 1'b0;
   logic        host_req_ready;
   logic        host_we = 1'b0;
   logic [11:0] host_addr = '0;
   logic [31:0] host_wdata = '0;
   logic        host_rsp_valid;
   logic [31:0] host_rsp_data;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        err_collision;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W     (12),
      .DATA_W     (32),
      .STARVE_MAX (3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdata      (cpu_rdata),
      .cpu_hold       (cpu_hold),
      .host_req_valid (host_req_valid),
      .host_req_ready (host_req_ready),
      .host_we        (host_we),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_rsp_valid (host_rsp_valid),
      .host_rsp_data  (host_rsp_data),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .err_collision  (err_collision)
   );

   // Behavioural 4096x32 single-port memory, synchronous read
   logic [31:0] mem [0:4095];
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
   end
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic        cr, cw;
      logic [11:0] ca;
      logic [31:0] cd;
      logic        hv, hw;
      logic [11:0] ha;
      logic [31:0] hd;
      logic        e_rdy, e_we;
      logic [11:0] e_addr;
      logic        e_rv;
      logic [31:0] e_rd;
      logic        e_hold;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(input logic cr, input logic cw, input logic [11:0] ca,
                               input logic [31:0] cd, input logic hv, input logic hw,
                               input logic [11:0] ha, input logic [31:0] hd,
                               input logic e_rdy, input logic e_we, input logic [11:0] e_addr,
                               input logic e_rv, input logic [31:0] e_rd, input logic e_hold);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.hv = hv; v.hw = hw; v.ha = ha; v.hd = hd;
      v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr;
      v.e_rv = e_rv; v.e_rd = e_rd; v.e_hold = e_hold;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                        input logic hv, input logic hw, input logic [11:0] ha, input logic [31:0] hd);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      host_req_valid = hv; host_we = hw; host_addr = ha; host_wdata = hd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Host write/read, CPU-vs-host contention, starvation, abandoned request
      vecs[0]  = mk(0,0,12'h000,32'h0,        1,1,12'h010,32'hDEADBEEF, 1,1,12'h010,0,32'h0,0);
      vecs[1]  = mk(0,0,12'h000,32'h0,        1,0,12'h010,32'h0,        1,0,12'h010,1,32'h0,0);
      vecs[2]  = mk(0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        1,0,12'h010,1,32'hDEADBEEF,0);
      vecs[3]  = mk(1,1,12'h020,32'h12345678, 1,0,12'h020,32'h0,        0,1,12'h020,0,32'h0,0);
      vecs[4]  = mk(0,0,12'h000,32'h0,        1,0,12'h020,32'h0,        1,0,12'h020,0,32'h0,0);
      vecs[5]  = mk(0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        1,0,12'h020,1,32'h12345678,0);
      vecs[6]  = mk(1,0,12'h030,32'h0,        1,0,12'h010,32'h0,        0,0,12'h030,0,32'h0,0);
      vecs[7]  = mk(1,0,12'h030,32'h0,        1,0,12'h010,32'h0,        0,0,12'h030,0,32'h0,0);
      vecs[8]  = mk(1,0,12'h030,32'h0,        1,0,12'h010,32'h0,        0,0,12'h030,0,32'h0,0);
      vecs[9]  = mk(0,0,12'h000,32'h0,        1,0,12'h010,32'h0,        1,0,12'h010,0,32'h0,1);
      vecs[10] = mk(1,0,12'h030,32'h0,        0,0,12'h000,32'h0,        0,0,12'h030,1,32'hDEADBEEF,0);
      vecs[11] = mk(0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        1,0,12'h030,0,32'h0,0);
      vecs[12] = mk(1,0,12'h040,32'h0,        1,1,12'h050,32'h000000A5, 0,0,12'h040,0,32'h0,0);
      vecs[13] = mk(1,0,12'h040,32'h0,        1,1,12'h050,32'h000000A5, 0,0,12'h040,0,32'h0,0);
      vecs[14] = mk(1,0,12'h040,32'h0,        0,0,12'h000,32'h0,        0,0,12'h040,0,32'h0,0);
      vecs[15] = mk(1,0,12'h040,32'h0,        0,0,12'h000,32'h0,        0,0,12'h040,0,32'h0,0);
      vecs[16] = mk(1,0,12'h040,32'h0,        1,1,12'h050,32'h000000A5, 0,0,12'h040,0,32'h0,0);
      vecs[17] = mk(1,0,12'h040,32'h0,        1,1,12'h050,32'h000000A5, 0,0,12'h040,0,32'h0,0);
      vecs[18] = mk(0,0,12'h000,32'h0,        1,1,12'h050,32'h000000A5, 1,1,12'h050,0,32'h0,0);
      vecs[19] = mk(0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        1,0,12'h050,1,32'h0,0);

      // Reset state
      #12;
      chk("reset_rsp_valid", {31'b0, host_rsp_valid}, 32'd0);
      chk("reset_rsp_data",  host_rsp_data, 32'd0);
      chk("reset_cpu_hold",  {31'b0, cpu_hold}, 32'd0);
      chk("reset_err",       {31'b0, err_collision}, 32'd0);
      chk("reset_mem_addr",  {20'b0, mem_addr}, 32'd0);
      chk("reset_mem_we",    {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Table-driven vectors, one clock per row
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
               vecs[i].hv, vecs[i].hw, vecs[i].ha, vecs[i].hd);
         @(negedge clk);
         $display("vec %0d: cpu_req=%0b host_valid=%0b ready=%0b mem_we=%0b mem_addr=%h rsp_valid=%0b rsp_data=%h hold=%0b",
                  i, cpu_req, host_req_valid, host_req_ready, mem_we, mem_addr,
                  host_rsp_valid, host_rsp_data, cpu_hold);
         chk($sformatf("v%0d_ready", i),     {31'b0, host_req_ready}, {31'b0, vecs[i].e_rdy});
         chk($sformatf("v%0d_mem_we", i),    {31'b0, mem_we},         {31'b0, vecs[i].e_we});
         chk($sformatf("v%0d_mem_addr", i),  {20'b0, mem_addr},       {20'b0, vecs[i].e_addr});
         chk($sformatf("v%0d_rsp_valid", i), {31'b0, host_rsp_valid}, {31'b0, vecs[i].e_rv});
         chk($sformatf("v%0d_rsp_data", i),  host_rsp_data,           vecs[i].e_rd);
         chk($sformatf("v%0d_cpu_hold", i),  {31'b0, cpu_hold},       {31'b0, vecs[i].e_hold});
         chk($sformatf("v%0d_err", i),       {31'b0, err_collision},  32'd0);
         next_cycle();
      end

      // Collision: CPU ignores cpu_hold
      for (int c = 0; c < 3; c++) begin
         drive(1,0,12'h020,32'h0, 1,0,12'h010,32'h0);
         @(negedge clk);
         chk("coll_blocked_hold", {31'b0, cpu_hold}, 32'd0);
         chk("coll_blocked_ready", {31'b0, host_req_ready}, 32'd0);
         next_cycle();
      end
      drive(1,0,12'h020,32'h0, 1,0,12'h010,32'h0);
      @(negedge clk);
      $display("collision cycle: hold=%0b ready=%0b mem_addr=%h err=%0b", cpu_hold, host_req_ready, mem_addr, err_collision);
      chk("coll_hold_high",   {31'b0, cpu_hold}, 32'd1);
      chk("coll_host_blocked",{31'b0, host_req_ready}, 32'd0);
      chk("coll_cpu_served",  {20'b0, mem_addr}, 32'h020);
      chk("coll_cpu_rdata",   cpu_rdata, 32'h12345678);
      next_cycle();
      drive(0,0,12'h000,32'h0, 1,0,12'h010,32'h0);
      @(negedge clk);
      $display("after collision: hold=%0b ready=%0b err=%0b", cpu_hold, host_req_ready, err_collision);
      chk("coll_err_set",     {31'b0, err_collision}, 32'd1);
      chk("coll_still_hold",  {31'b0, cpu_hold}, 32'd1);
      chk("coll_accept",      {31'b0, host_req_ready}, 32'd1);
      chk("coll_host_addr",   {20'b0, mem_addr}, 32'h010);
      next_cycle();
      drive(0,0,12'h000,32'h0, 0,0,12'h000,32'h0);
      @(negedge clk);
      $display("collision response: valid=%0b data=%h hold=%0b err=%0b", host_rsp_valid, host_rsp_data, cpu_hold, err_collision);
      chk("coll_hold_fell",   {31'b0, cpu_hold}, 32'd0);
      chk("coll_rsp_valid",   {31'b0, host_rsp_valid}, 32'd1);
      chk("coll_rsp_data",    host_rsp_data, 32'hDEADBEEF);
      chk("coll_err_sticky",  {31'b0, err_collision}, 32'd1);
      next_cycle();

      // Reset between accept and response
      drive(0,0,12'h000,32'h0, 1,0,12'h020,32'h0);
      @(negedge clk);
      chk("rst_pre_accept", {31'b0, host_req_ready}, 32'd1);
      rst_n = 1'b0;
      drive(0,0,12'h000,32'h0, 0,0,12'h000,32'h0);
      #1;
      $display("in reset: valid=%0b hold=%0b err=%0b mem_addr=%h", host_rsp_valid, cpu_hold, err_collision, mem_addr);
      chk("rst_rsp_valid", {31'b0, host_rsp_valid}, 32'd0);
      chk("rst_rsp_data",  host_rsp_data, 32'd0);
      chk("rst_err",       {31'b0, err_collision}, 32'd0);
      chk("rst_hold",      {31'b0, cpu_hold}, 32'd0);
      chk("rst_mem_addr",  {20'b0, mem_addr}, 32'd0);
      #1;
      rst_n = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("rst_no_rsp",    {31'b0, host_rsp_valid}, 32'd0);
      chk("rst_err_clear", {31'b0, err_collision}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-port data memory (`MEM`, 4096×32, synchronous read). It shares that memory between the processor's MM-stage access and a host port used for debug and program load. The processor always wins a cycle in which it requests. A starvation counter guarantees host progress by raising `cpu_hold`, which asks the pipeline to skip its memory slot for one cycle.

## Interface
Parameters:
- `ADDR_W`, 12, word-address width of the data memory
- `DATA_W`, 32, data width
- `STARVE_MAX`, 15, number of blocked host cycles before `cpu_hold` is asserted (legal range 1..255)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cpu_req`  in  1  processor memory access this cycle (load or store, already valid-qualified)
- `cpu_we`  in  1  processor store
- `cpu_addr`  in  ADDR_W  processor word address
- `cpu_wdata`  in  DATA_W  processor store data
- `cpu_rdata`  out  DATA_W  load data; valid the cycle after `cpu_req`
- `cpu_hold`  out  1  registered; processor must not assert `cpu_req` while high
- `host_req_valid`  in  1  host request
- `host_req_ready`  out  1  host request accepted when both valid and ready are high
- `host_we`  in  1  host write
- `host_addr`  in  ADDR_W  host word address
- `host_wdata`  in  DATA_W  host write data
- `host_rsp_valid`  out  1  one-cycle pulse, one per accepted request
- `host_rsp_data`  out  DATA_W  read data; 0 for writes
- `mem_addr`  out  ADDR_W  to the dmem address port
- `mem_we`  out  1  to the dmem write enable
- `mem_wdata`  out  DATA_W  to the dmem data input
- `mem_rdata`  in  DATA_W  dmem output, one cycle after the address
- `err_collision`  out  1  sticky; set when `cpu_req` is seen while `cpu_hold` is high

## Operation
- Grant rule, combinational each cycle:
  - `cpu_req` = 1: the CPU drives `mem_*` and `host_req_ready` = 0.
  - Otherwise: `host_req_ready` = 1, and on accept the host drives `mem_*`.
  - Otherwise: `mem_we` = 0 and `mem_addr` holds its last value.
- `mem_we` is asserted only for the granted requester's write.
- Host accept registers `rsp_pend` = 1 and `rsp_is_rd` = !`host_we`. The next cycle:
  - `host_rsp_valid` = 1.
  - `host_rsp_data` = `mem_rdata` if `rsp_is_rd`, else 0.
- `cpu_rdata` is a direct pass-through of `mem_rdata`. Its timing is owned by the processor.
- Host protocol: `host_req_valid` and payload are held stable until accept. The response has no backpressure.
- State machine, states IDLE, WAIT, HOLD:
  - IDLE → WAIT: `host_req_valid` && !accept.
  - WAIT: `starve_cnt` increments each blocked cycle and is cleared on accept, which returns to IDLE.
    - Counter width: 8 bits, saturating.
    - WAIT → HOLD when the counter reaches `STARVE_MAX`.
  - HOLD: `cpu_hold` = 1.
    - Accept → IDLE, counter cleared.
    - `host_req_valid` dropped → IDLE, counter cleared.
  - IDLE with accept in the same cycle as valid: remain in IDLE.
- Collision in HOLD: if `cpu_req` = 1 while `cpu_hold` = 1:
  - The CPU still wins.
  - `err_collision` is set and stays set until reset.
  - The FSM stays in HOLD.
- CPU write and CPU read to the same address the host reads: there is no ordering beyond grant order. Whichever request is granted first is performed first.

## Timing
- Reset, asynchronous: state IDLE, `starve_cnt` = 0, `cpu_hold` = 0, `rsp_pend` = 0, `host_rsp_valid` = 0, `host_rsp_data` = 0, `err_collision` = 0, held `mem_addr` = 0.
- Reset mid-transaction kills any pending response; no `host_rsp_valid` is issued after reset.
- Host latency:
  - Uncontended: accept in cycle N, `host_rsp_valid` in N+1.
  - Worst case with a continuously requesting CPU: `STARVE_MAX` blocked cycles, then `cpu_hold` high in the next cycle, with accept in that same cycle. Accept is therefore at cycle `STARVE_MAX`+1 after first valid, and the response follows in the cycle after accept.
- `cpu_hold` is high for exactly one cycle per starvation event when the processor obeys it.
- Back-to-back host requests are accepted every cycle. `host_rsp_valid` may then be high continuously.

## Structure
- The shared package `dmem_pkg` holds:
  - the state enum (IDLE/WAIT/HOLD);
  - `DMEM_ADDR_W` = 12 and `DMEM_DATA_W` = 32;
  - the request struct {we, addr, wdata}.
- One sub-module: `starve_counter` (8-bit saturating up-counter with clear, terminal-count compare against `STARVE_MAX`).
- Everything else lives in `dmem_arbiter`.

## Test plan
- Host only, after reset: write 0xDEADBEEF to 0x010, then read 0x010.
  - Both accepted in the cycle valid rises.
  - Write rsp data = 0; read rsp data = 0xDEADBEEF, one cycle after accept.
- CPU and host both request in the same cycle:
  - CPU store 0x12345678 to 0x020 goes to memory.
  - `host_req_ready` = 0.
  - Host read of 0x020 accepted the next idle cycle and returns 0x12345678.
- Starvation with `STARVE_MAX` = 3, CPU requesting every cycle that `cpu_hold` is low:
  - `cpu_hold` rises after 3 blocked cycles.
  - Host is accepted in the hold cycle and `cpu_hold` falls the next cycle.
- Collision:
  - CPU keeps `cpu_req` = 1 during `cpu_hold`.
  - `err_collision` = 1 and stays set; CPU is served; host stays unaccepted.
- Host abandons a request in WAIT: FSM goes to IDLE, counter = 0, `cpu_hold` never asserts.
- `rst_n` pulsed low between accept and response: `host_rsp_valid` stays 0 and all outputs return to reset values immediately.
